// File: rtl/pe_twiddle_multiplier_pipe.sv
// Three-stage complex multiply by W^k = exp(-j*2*pi*k/TWIDDLE_RANK) for the FFT PE datapath.
// S1 registers operands and coefficients, S2 forms the four products, S3 rounds and saturates.
module pe_twiddle_multiplier_pipe #(
  parameter int DATA_WIDTH_IN  = 10,
  parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + 1,
  parameter int TWIDDLE_RANK   = 8,
  parameter int TW_WIDTH       = ($clog2(TWIDDLE_RANK) > 1) ? $clog2(TWIDDLE_RANK) - 1 : 1,
  parameter int COEF_FRAC      = 14,
  parameter int USER_WIDTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [TW_WIDTH-1:0]              twiddle,
  input  logic signed [DATA_WIDTH_IN-1:0]  din_real,
  input  logic signed [DATA_WIDTH_IN-1:0]  din_imag,
  input  logic [USER_WIDTH-1:0]            in_user,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DATA_WIDTH_OUT-1:0] dout_real,
  output logic signed [DATA_WIDTH_OUT-1:0] dout_imag,
  output logic [USER_WIDTH-1:0]            out_user,
  output logic                             sat_flag
);

  localparam int CW      = COEF_FRAC + 2;             // holds +1.0 exactly
  localparam int PW      = DATA_WIDTH_IN + CW;
  localparam int SW      = PW + 1;
  localparam int QSHIFT  = 30 - COEF_FRAC;
  localparam int M_SHIFT = 4 - $clog2(TWIDDLE_RANK);  // maps k onto a 16-point angle grid

  if (!(TWIDDLE_RANK == 2 || TWIDDLE_RANK == 4 || TWIDDLE_RANK == 8 || TWIDDLE_RANK == 16)) begin : g_bad_rank
    $error("TWIDDLE_RANK must be 2, 4, 8 or 16");
  end
  if (COEF_FRAC < 1 || COEF_FRAC > 29) begin : g_bad_frac
    $error("COEF_FRAC must be in 1..29");
  end
  if (DATA_WIDTH_OUT < DATA_WIDTH_IN + 1 || DATA_WIDTH_OUT > DATA_WIDTH_IN + 3) begin : g_bad_wout
    $error("DATA_WIDTH_OUT must be DATA_WIDTH_IN+1 .. DATA_WIDTH_IN+3");
  end

  // Magnitudes are held in Q30 and rounded half-away-from-zero to COEF_FRAC bits.
  function automatic logic signed [CW-1:0] quant(input longint mag, input bit neg);
    longint r;
    r = (mag + (longint'(1) <<< (QSHIFT - 1))) >>> QSHIFT;
    if (neg) r = -r;
    return CW'(r);
  endfunction

  localparam logic signed [CW-1:0] K_ONE  = quant(longint'(1) <<< 30, 1'b0);
  localparam logic signed [CW-1:0] K_C16  = quant(992008094, 1'b0);  // cos(pi/8)
  localparam logic signed [CW-1:0] K_S16  = quant(410903207, 1'b0);  // sin(pi/8)
  localparam logic signed [CW-1:0] K_R2   = quant(759250125, 1'b0);  // sqrt(2)/2
  localparam logic signed [CW-1:0] K_NC16 = quant(992008094, 1'b1);
  localparam logic signed [CW-1:0] K_NS16 = quant(410903207, 1'b1);
  localparam logic signed [CW-1:0] K_NR2  = quant(759250125, 1'b1);

  localparam logic signed [SW-1:0] RND  = {{(SW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_WIDTH_OUT+1){1'b0}}, {(DATA_WIDTH_OUT-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DATA_WIDTH_OUT+1){1'b1}}, {(DATA_WIDTH_OUT-1){1'b0}}};

  logic                             adv;
  logic [2:0]                       tw3, m;
  logic signed [CW-1:0]             coef_c, coef_s;
  logic signed [SW-1:0]             sum_re, sum_im;
  logic                             re_hi, re_lo, im_hi, im_lo;
  logic signed [DATA_WIDTH_OUT-1:0] re_sat, im_sat;

  logic                             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DATA_WIDTH_IN-1:0]  a1_q, a1_d, b1_q, b1_d;
  logic signed [CW-1:0]             c1_q, c1_d, s1_q, s1_d;
  logic [USER_WIDTH-1:0]            u1_q, u1_d, u2_q, u2_d, u3_q, u3_d;
  logic signed [PW-1:0]             p_ac_q, p_ac_d, p_bs_q, p_bs_d, p_bc_q, p_bc_d, p_as_q, p_as_d;
  logic signed [DATA_WIDTH_OUT-1:0] re3_q, re3_d, im3_q, im3_d;
  logic                             sat3_q, sat3_d;

  // Trivial angles use +/-1.0 and 0 coefficients, which round back to the exact operand.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    coef_c = K_ONE;
    coef_s = '0;
    tw3    = 3'(twiddle);
    m      = tw3 << M_SHIFT;
    case (m)
      3'd0: begin coef_c = K_ONE;  coef_s = '0;    end
      3'd1: begin coef_c = K_C16;  coef_s = K_S16; end
      3'd2: begin coef_c = K_R2;   coef_s = K_R2;  end
      3'd3: begin coef_c = K_S16;  coef_s = K_C16; end
      3'd4: begin coef_c = '0;     coef_s = K_ONE; end
      3'd5: begin coef_c = K_NS16; coef_s = K_C16; end
      3'd6: begin coef_c = K_NR2;  coef_s = K_R2;  end
      3'd7: begin coef_c = K_NC16; coef_s = K_S16; end
      default: ;
    endcase
  end

  always_comb begin
    sum_re = SW'(p_ac_q) + SW'(p_bs_q) + RND;
    sum_im = SW'(p_bc_q) - SW'(p_as_q) + RND;
    re_hi  = (sum_re >>> COEF_FRAC) > MAXV;
    re_lo  = (sum_re >>> COEF_FRAC) < MINV;
    im_hi  = (sum_im >>> COEF_FRAC) > MAXV;
    im_lo  = (sum_im >>> COEF_FRAC) < MINV;
    re_sat = re_hi ? MAXV[DATA_WIDTH_OUT-1:0] :
             re_lo ? MINV[DATA_WIDTH_OUT-1:0] : sum_re[COEF_FRAC +: DATA_WIDTH_OUT];
    im_sat = im_hi ? MAXV[DATA_WIDTH_OUT-1:0] :
             im_lo ? MINV[DATA_WIDTH_OUT-1:0] : sum_im[COEF_FRAC +: DATA_WIDTH_OUT];
  end

  // The whole pipe moves as one; bubbles shift too, so a stall only freezes a full output.
  assign adv = out_ready || !v3_q;

  always_comb begin
    v1_d = v1_q;  a1_d = a1_q;  b1_d = b1_q;  c1_d = c1_q;  s1_d = s1_q;  u1_d = u1_q;
    v2_d = v2_q;  p_ac_d = p_ac_q;  p_bs_d = p_bs_q;  p_bc_d = p_bc_q;  p_as_d = p_as_q;  u2_d = u2_q;
    v3_d = v3_q;  re3_d = re3_q;  im3_d = im3_q;  u3_d = u3_q;  sat3_d = sat3_q;
    if (adv) begin
      v1_d   = in_valid;
      a1_d   = din_real;
      b1_d   = din_imag;
      c1_d   = coef_c;
      s1_d   = coef_s;
      u1_d   = in_user;
      v2_d   = v1_q;
      p_ac_d = PW'(a1_q) * PW'(c1_q);
      p_bs_d = PW'(b1_q) * PW'(s1_q);
      p_bc_d = PW'(b1_q) * PW'(c1_q);
      p_as_d = PW'(a1_q) * PW'(s1_q);
      u2_d   = u1_q;
      v3_d   = v2_q;
      re3_d  = re_sat;
      im3_d  = im_sat;
      u3_d   = u2_q;
      sat3_d = re_hi | re_lo | im_hi | im_lo;
    end
  end

  // NOTE: datapath flops are reset as well, because the outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;  a1_q <= '0;  b1_q <= '0;  c1_q <= '0;  s1_q <= '0;  u1_q <= '0;
      v2_q <= 1'b0;  p_ac_q <= '0;  p_bs_q <= '0;  p_bc_q <= '0;  p_as_q <= '0;  u2_q <= '0;
      v3_q <= 1'b0;  re3_q <= '0;  im3_q <= '0;  u3_q <= '0;  sat3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every stage samples the previous stage's old value.
      v1_q <= v1_d;  a1_q <= a1_d;  b1_q <= b1_d;  c1_q <= c1_d;  s1_q <= s1_d;  u1_q <= u1_d;
      v2_q <= v2_d;  p_ac_q <= p_ac_d;  p_bs_q <= p_bs_d;  p_bc_q <= p_bc_d;  p_as_q <= p_as_d;
      u2_q <= u2_d;
      v3_q <= v3_d;  re3_q <= re3_d;  im3_q <= im3_d;  u3_q <= u3_d;  sat3_q <= sat3_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign dout_real = re3_q;
  assign dout_imag = im3_q;
  assign out_user  = u3_q;
  assign sat_flag  = sat3_q;

endmodule

// File: tb/tb_pe_twiddle_multiplier_pipe.sv
// Bench for pe_twiddle_multiplier_pipe: four instances (ranks 2/4/8/16) fed the same samples,
// checked against a reference model through a scoreboard queue.
module tb_pe_twiddle_multiplier_pipe;

  localparam int WI = 10;
  localparam int WO = 11;
  localparam int UW = 4;

  typedef struct {
    int a, b, k8, k16, k4, k2, user;
    bit ovr;
    int re8, im8, re16, im16;
  } vec_t;

  typedef struct {
    int re[4];
    int im[4];
    bit sat[4];
    int user;
    int cyc;
    bit lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [WI-1:0] din_real = '0, din_imag = '0;
  logic [UW-1:0]        in_user = '0;
  logic [0:0]           tw2 = '0, tw4 = '0;
  logic [1:0]           tw8 = '0;
  logic [2:0]           tw16 = '0;

  logic                 ir2, ir4, ir8, ir16, ov2, ov4, ov8, ov16, sf2, sf4, sf8, sf16;
  logic signed [WO-1:0] dr2, di2, dr4, di4, dr8, di8, dr16, di16;
  logic [UW-1:0]        ou2, ou4, ou8, ou16;

  pe_twiddle_multiplier_pipe #(.TWIDDLE_RANK(2)) u_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .twiddle(tw2),
    .din_real(din_real), .din_imag(din_imag), .in_user(in_user), .out_valid(ov2),
    .out_ready(out_ready), .dout_real(dr2), .dout_imag(di2), .out_user(ou2), .sat_flag(sf2));
  pe_twiddle_multiplier_pipe #(.TWIDDLE_RANK(4)) u_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .twiddle(tw4),
    .din_real(din_real), .din_imag(din_imag), .in_user(in_user), .out_valid(ov4),
    .out_ready(out_ready), .dout_real(dr4), .dout_imag(di4), .out_user(ou4), .sat_flag(sf4));
  pe_twiddle_multiplier_pipe #(.TWIDDLE_RANK(8)) u_r8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .twiddle(tw8),
    .din_real(din_real), .din_imag(din_imag), .in_user(in_user), .out_valid(ov8),
    .out_ready(out_ready), .dout_real(dr8), .dout_imag(di8), .out_user(ou8), .sat_flag(sf8));
  pe_twiddle_multiplier_pipe #(.TWIDDLE_RANK(16)) u_r16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .twiddle(tw16),
    .din_real(din_real), .din_imag(din_imag), .in_user(in_user), .out_valid(ov16),
    .out_ready(out_ready), .dout_real(dr16), .dout_imag(di16), .out_user(ou16), .sat_flag(sf16));

  int gre[4], gim[4], gu[4];
  bit gv[4], gs[4], gir[4];
  always_comb begin
    gre[0] = int'(dr2);  gim[0] = int'(di2);  gu[0] = int'(ou2);  gv[0] = ov2;  gs[0] = sf2;  gir[0] = ir2;
    gre[1] = int'(dr4);  gim[1] = int'(di4);  gu[1] = int'(ou4);  gv[1] = ov4;  gs[1] = sf4;  gir[1] = ir4;
    gre[2] = int'(dr8);  gim[2] = int'(di8);  gu[2] = int'(ou8);  gv[2] = ov8;  gs[2] = sf8;  gir[2] = ir8;
    gre[3] = int'(dr16); gim[3] = int'(di16); gu[3] = int'(ou16); gv[3] = ov16; gs[3] = sf16; gir[3] = ir16;
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   popped = 0;
  bit   lat_mode = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Reference: exact trivial angles, quantised constants otherwise, floor after +half, clamp.
  function automatic void model(input int rank, input int k, input int a, input int b,
                                output int re, output int im, output bit sat);
    longint c, s, xr, xi;
    int kk;
    case (rank)
      2:       kk = 0;
      4:       kk = k & 1;
      8:       kk = k & 3;
      default: kk = k & 7;
    endcase
    sat = 1'b0;
    if (kk == 0) begin re = a; im = b; return; end
    if (kk == rank / 4) begin re = b; im = -a; return; end
    c = 0; s = 0;
    if (rank == 8) begin
      c = (kk == 1) ? 11585 : -11585;
      s = 11585;
    end else begin
      case (kk)
        1: begin c = 15137;  s = 6270;  end
        2: begin c = 11585;  s = 11585; end
        3: begin c = 6270;   s = 15137; end
        5: begin c = -6270;  s = 15137; end
        6: begin c = -11585; s = 11585; end
        7: begin c = -15137; s = 6270;  end
        default: ;
      endcase
    end
    xr = (longint'(a) * c + longint'(b) * s + 8192) >>> 14;
    xi = (longint'(b) * c - longint'(a) * s + 8192) >>> 14;
    if (xr > 1023) begin xr = 1023; sat = 1'b1; end else if (xr < -1024) begin xr = -1024; sat = 1'b1; end
    if (xi > 1023) begin xi = 1023; sat = 1'b1; end else if (xi < -1024) begin xi = -1024; sat = 1'b1; end
    re = int'(xr);
    im = int'(xi);
  endfunction

  // Call at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input vec_t v);
    exp_t e;
    bit   acc;
    int   n;
    din_real = v.a[WI-1:0];
    din_imag = v.b[WI-1:0];
    tw2      = v.k2[0:0];
    tw4      = v.k4[0:0];
    tw8      = v.k8[1:0];
    tw16     = v.k16[2:0];
    in_user  = v.user[UW-1:0];
    in_valid = 1'b1;
    model(2,  v.k2,  v.a, v.b, e.re[0], e.im[0], e.sat[0]);
    model(4,  v.k4,  v.a, v.b, e.re[1], e.im[1], e.sat[1]);
    model(8,  v.k8,  v.a, v.b, e.re[2], e.im[2], e.sat[2]);
    model(16, v.k16, v.a, v.b, e.re[3], e.im[3], e.sat[3]);
    if (v.ovr) begin
      e.re[2] = v.re8;  e.im[2] = v.im8;
      e.re[3] = v.re16; e.im[3] = v.im16;
    end
    e.user = v.user & ((1 << UW) - 1);
    e.lat  = lat_mode;
    e.cyc  = 0;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc   = ir8;
      e.cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end else begin
      sb.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_queue_left"}, sb.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("%s_out_valid_r%0d", tag, 2 << r), int'(gv[r]), 0);
      check($sformatf("%s_dout_real_r%0d", tag, 2 << r), gre[r], 0);
      check($sformatf("%s_dout_imag_r%0d", tag, 2 << r), gim[r], 0);
      check($sformatf("%s_out_user_r%0d", tag, 2 << r), gu[r], 0);
      check($sformatf("%s_sat_flag_r%0d", tag, 2 << r), int'(gs[r]), 0);
    end
  endtask

  // Output monitor: outputs sampled on the falling edge, compared to the queue head every
  // cycle they are valid (so held outputs are re-checked), popped on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (gv[0] || gv[1] || gv[2] || gv[3])) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got out_valid with user %0d expected no beat", gu[2]);
      end else begin
        e = sb[0];
        for (int r = 0; r < 4; r++) begin
          check($sformatf("out_valid_r%0d", 2 << r), int'(gv[r]), 1);
          check($sformatf("dout_real_r%0d_tag%0d", 2 << r, e.user), gre[r], e.re[r]);
          check($sformatf("dout_imag_r%0d_tag%0d", 2 << r, e.user), gim[r], e.im[r]);
          check($sformatf("sat_flag_r%0d_tag%0d", 2 << r, e.user), int'(gs[r]), int'(e.sat[r]));
          check($sformatf("out_user_r%0d", 2 << r), gu[r], e.user);
        end
        if (!out_ready)
          for (int r = 0; r < 4; r++) check($sformatf("in_ready_stall_r%0d", 2 << r), int'(gir[r]), 0);
        if (out_ready) begin
          if (e.lat) check($sformatf("latency_tag%0d", e.user), cyc - e.cyc, 3);
          void'(sb.pop_front());
          popped++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   p0;
    bit   done;

    tbl[0] = '{a:256,  b:0,    k8:1, k16:0, k4:0, k2:1, user:1, ovr:1, re8:181,  im8:-181, re16:256,  im16:0};
    tbl[1] = '{a:100,  b:-50,  k8:2, k16:4, k4:1, k2:0, user:2, ovr:1, re8:-50,  im8:-100, re16:-50,  im16:-100};
    tbl[2] = '{a:-512, b:-512, k8:2, k16:0, k4:1, k2:1, user:3, ovr:1, re8:-512, im8:512,  re16:-512, im16:-512};
    tbl[3] = '{a:-512, b:7,    k8:0, k16:4, k4:0, k2:0, user:4, ovr:1, re8:-512, im8:7,    re16:7,    im16:512};
    tbl[4] = '{a:511,  b:0,    k8:0, k16:1, k4:1, k2:1, user:5, ovr:1, re8:511,  im8:0,    re16:472,  im16:-196};
    tbl[5] = '{a:0,    b:511,  k8:3, k16:3, k4:0, k2:0, user:6, ovr:1, re8:361,  im8:-361, re16:472,  im16:196};
    tbl[6] = '{a:-512, b:-512, k8:1, k16:2, k4:1, k2:0, user:7, ovr:1, re8:-724, im8:0,    re16:-724, im16:0};
    tbl[7] = '{a:511,  b:511,  k8:1, k16:7, k4:0, k2:1, user:8, ovr:1, re8:723,  im8:0,    re16:-277, im16:-668};

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #2;
    check_idle("in_reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("post_reset");
    for (int r = 0; r < 4; r++) check($sformatf("post_reset_in_ready_r%0d", 2 << r), int'(gir[r]), 1);

    // Directed vectors, streamed back to back, latency checked on each.
    lat_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(tbl[i]);
    drain("table");
    lat_mode = 1'b0;

    // Eight tagged beats with a five-cycle downstream stall mid-stream.
    p0   = popped;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          v = '{a:int'($urandom_range(0, 1022)) - 511, b:int'($urandom_range(0, 1022)) - 511,
                k8:int'($urandom_range(0, 3)), k16:int'($urandom_range(0, 7)),
                k4:int'($urandom_range(0, 1)), k2:int'($urandom_range(0, 1)),
                user:i, ovr:0, re8:0, im8:0, re16:0, im16:0};
          send(v);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall");
    check("stall_beats_delivered", popped - p0, 8);

    // Reset with three beats in flight: nothing may survive it.
    for (int i = 0; i < 3; i++) begin
      v = '{a:100 + i, b:-20 * i, k8:1, k16:3, k4:1, k2:0, user:9 + i, ovr:0,
            re8:0, im8:0, re16:0, im16:0};
      send(v);
    end
    #1 rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    lat_mode = 1'b1;
    send(tbl[0]);
    drain("after_reset");
    lat_mode = 1'b0;

    // Random sweep over every rank and k with random downstream back-pressure.
    p0   = popped;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          v = '{a:int'($urandom_range(0, 1022)) - 511, b:int'($urandom_range(0, 1022)) - 511,
                k8:int'($urandom_range(0, 3)), k16:int'($urandom_range(0, 7)),
                k4:int'($urandom_range(0, 1)), k2:int'($urandom_range(0, 1)),
                user:i % 16, ovr:0, re8:0, im8:0, re16:0, im16:0};
          send(v);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");
    check("random_beats_delivered", popped - p0, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
